// File: rtl/ext_arbiter.sv
// ext_arbiter: two-requester shared 32-bit extender (immediate / load path)
// with a one-entry result register. EXT_ARB_LUI_EN enables the LUI shifter.
module ext_arbiter #(
    parameter logic PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imm_valid,
    output logic        imm_ready,
    input  logic [15:0] imm_data,
    input  logic [1:0]  imm_mode,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_offset,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_src
);

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic        state;
    logic        last_ld;
    logic        slot_free;
    logic        pick_ld;
    logic        xfer;
    logic [31:0] imm_ext;
    logic [31:0] ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Immediate extension; mode 11 falls back to sign extension
    always_comb begin
        imm_ext = {{16{imm_data[15]}}, imm_data};
        case (imm_mode)
            2'b01:   imm_ext = {16'h0000, imm_data};
`ifdef EXT_ARB_LUI_EN
            2'b10:   imm_ext = {imm_data, 16'h0000};
`else
            2'b10:   imm_ext = {16'h0000, imm_data};
`endif
            default: imm_ext = {{16{imm_data[15]}}, imm_data};
        endcase
    end

    // Load lane extraction (little-endian) and sign/zero fill
    always_comb begin
        case (ld_offset)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            2'b00:   ld_ext = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ld_ext = ld_word;
        endcase
    end

    // Grant: lone requester wins; conflicts go round-robin or fixed to imm
    always_comb begin
        pick_ld = ld_valid;
        if (imm_valid && ld_valid) begin
            pick_ld = PRIO_FIXED ? 1'b0 : !last_ld;
        end
    end

    assign res_valid = (state == FULL);
    assign slot_free = (state == EMPTY) || res_ready;
    assign imm_ready = rst_n && slot_free && imm_valid && !pick_ld;
    assign ld_ready  = rst_n && slot_free && ld_valid && pick_ld;
    assign xfer      = imm_ready || ld_ready;

    // Result register, occupancy state and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            res_data <= 32'h0;
            res_src  <= 1'b0;
            last_ld  <= 1'b1;
        end else if (xfer) begin
            state    <= FULL;
            res_data <= pick_ld ? ld_ext : imm_ext;
            res_src  <= pick_ld;
            last_ld  <= pick_ld;
        end else if (res_ready) begin
            state    <= EMPTY;
        end
    end

endmodule

// File: tb/tb_ext_arbiter.sv
// tb_ext_arbiter: directed scenarios plus randomized traffic against a
// behavioural reference model of the shared extender.
module tb_ext_arbiter;

    localparam logic PRIO = 1'b0;

    logic        clk;
    logic        rst_n;
    logic        imm_valid;
    logic        imm_ready;
    logic [15:0] imm_data;
    logic [1:0]  imm_mode;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_word;
    logic [1:0]  ld_offset;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_src;

    int n_checks;
    int n_fail;

    ext_arbiter #(.PRIO_FIXED(PRIO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imm_valid(imm_valid), .imm_ready(imm_ready),
        .imm_data(imm_data), .imm_mode(imm_mode),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_word(ld_word), .ld_offset(ld_offset),
        .ld_size(ld_size), .ld_signed(ld_signed),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_src(res_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_imm(input logic [15:0] d,
                                            input logic [1:0] m);
        logic [31:0] r;
        if (m == 2'd1) r = 32'(d);
        else if (m == 2'd2) begin
`ifdef EXT_ARB_LUI_EN
            r = 32'(d) << 16;
`else
            r = 32'(d);
`endif
        end else r = 32'($signed(d));
        return r;
    endfunction

    function automatic logic [31:0] ref_ld(input logic [31:0] w,
                                           input logic [1:0] off,
                                           input logic [1:0] sz,
                                           input logic sg);
        logic [31:0] f;
        int sh;
        if (sz >= 2'd2) return w;
        if (sz == 2'd0) begin
            sh = 8 * int'(off);
            f = (w >> sh) & 32'hFF;
            if (sg && f[7]) f = f | 32'hFFFF_FF00;
        end else begin
            sh = (off >= 2'd2) ? 16 : 0;
            f = (w >> sh) & 32'hFFFF;
            if (sg && f[15]) f = f | 32'hFFFF_0000;
        end
        return f;
    endfunction

    logic        m_valid;
    logic [31:0] m_data;
    logic        m_src;
    logic        m_last_ld;
    logic        imm_acc;
    logic        ld_acc;
    logic        free;
    logic        win_ld;
    logic        e_irdy;
    logic        e_lrdy;

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        imm_valid = 1'b1;
        imm_data = 16'h0;
        imm_mode = 2'd0;
        ld_valid = 1'b0;
        ld_word = 32'h0;
        ld_offset = 2'd0;
        ld_size = 2'd0;
        ld_signed = 1'b0;
        res_ready = 1'b0;

        #12;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", res_data, 32'h0);
        chk("rst_src", 32'(res_src), 32'd0);
        chk("rst_imm_rdy", 32'(imm_ready), 32'd0);
        chk("rst_ld_rdy", 32'(ld_ready), 32'd0);
        imm_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        imm_data = 16'h8000;
        imm_mode = 2'd0;
        imm_valid = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("sx_rdy", 32'(imm_ready), 32'd1);
        tick();
        chk("sx_valid", 32'(res_valid), 32'd1);
        chk("sx_data", res_data, 32'hFFFF_8000);
        chk("sx_src", 32'(res_src), 32'd0);
        imm_mode = 2'd1;
        tick();
        chk("zx_data", res_data, 32'h0000_8000);
        imm_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(res_valid), 32'd0);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        imm_data = 16'h0001;
        imm_mode = 2'd0;
        imm_valid = 1'b1;
        ld_word = 32'h1234_5678;
        ld_offset = 2'd3;
        ld_size = 2'd0;
        ld_signed = 1'b1;
        ld_valid = 1'b1;
        #1;
        chk("cf_imm_rdy", 32'(imm_ready), 32'd1);
        chk("cf_ld_rdy", 32'(ld_ready), 32'd0);
        tick();
        chk("cf1_data", res_data, 32'h0000_0001);
        chk("cf1_src", 32'(res_src), 32'd0);
        imm_valid = 1'b0;
        tick();
        chk("cf2_data", res_data, 32'h0000_0012);
        chk("cf2_src", 32'(res_src), 32'd1);

        ld_word = 32'h80FF_1234;
        ld_offset = 2'd2;
        ld_size = 2'd1;
        ld_signed = 1'b1;
        tick();
        chk("hs_data", res_data, 32'hFFFF_80FF);
        ld_signed = 1'b0;
        tick();
        chk("hz_data", res_data, 32'h0000_80FF);
        chk("hz_src", 32'(res_src), 32'd1);
        ld_valid = 1'b0;
        tick();

        res_ready = 1'b0;
        imm_data = 16'h0055;
        imm_mode = 2'd1;
        imm_valid = 1'b1;
        ld_word = 32'hCAFE_BABE;
        ld_size = 2'd2;
        ld_valid = 1'b1;
        tick();
        chk("bp_first", res_data, 32'h0000_0055);
        chk("bp_src", 32'(res_src), 32'd0);
        imm_data = 16'h0066;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_data", res_data, 32'h0000_0055);
            chk("bp_hold_valid", 32'(res_valid), 32'd1);
            chk("bp_imm_rdy", 32'(imm_ready), 32'd0);
            chk("bp_ld_rdy", 32'(ld_ready), 32'd0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_rel_ld_rdy", 32'(ld_ready), 32'd1);
        chk("bp_rel_imm_rdy", 32'(imm_ready), 32'd0);
        tick();
        chk("bp_ld_data", res_data, 32'hCAFE_BABE);
        chk("bp_ld_src", 32'(res_src), 32'd1);
        ld_valid = 1'b0;
        tick();
        chk("bp_imm_data", res_data, 32'h0000_0066);
        imm_valid = 1'b0;
        tick();

        imm_data = 16'h1234;
        imm_mode = 2'd2;
        imm_valid = 1'b1;
        tick();
`ifdef EXT_ARB_LUI_EN
        chk("lui", res_data, 32'h1234_0000);
`else
        chk("lui", res_data, 32'h0000_1234);
`endif
        imm_valid = 1'b0;
        tick();

        res_ready = 1'b0;
        imm_data = 16'h00AB;
        imm_mode = 2'd0;
        imm_valid = 1'b1;
        tick();
        imm_valid = 1'b0;
        chk("ar_full", 32'(res_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(res_valid), 32'd0);
        chk("ar_data", res_data, 32'h0);
        #2;
        rst_n = 1'b1;
        res_ready = 1'b1;
        imm_valid = 1'b1;
        ld_word = 32'h0000_00F0;
        ld_size = 2'd0;
        ld_offset = 2'd0;
        ld_signed = 1'b1;
        ld_valid = 1'b1;
        #1;
        chk("ar_imm_rdy", 32'(imm_ready), 32'd1);
        chk("ar_ld_rdy", 32'(ld_ready), 32'd0);
        tick();
        chk("ar_src1", 32'(res_src), 32'd0);
        imm_valid = 1'b0;
        tick();
        chk("ar_src2", 32'(res_src), 32'd1);
        chk("ar_data2", res_data, 32'hFFFF_FFF0);
        ld_valid = 1'b0;
        tick();

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_valid = 1'b0;
        m_data = 32'h0;
        m_src = 1'b0;
        m_last_ld = 1'b1;
        imm_acc = 1'b0;
        ld_acc = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            chk("rnd_valid", 32'(res_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rnd_data", res_data, m_data);
                chk("rnd_src", 32'(res_src), 32'(m_src));
            end
            if (!imm_valid || imm_acc) begin
                imm_valid = ($urandom % 3) != 0;
                imm_data = 16'($urandom);
                imm_mode = 2'($urandom);
            end
            if (!ld_valid || ld_acc) begin
                ld_valid = ($urandom % 3) != 0;
                ld_word = $urandom;
                ld_offset = 2'($urandom);
                ld_size = 2'($urandom);
                ld_signed = 1'($urandom);
            end
            res_ready = ($urandom % 4) != 0;
            #1;
            free = !m_valid || res_ready;
            if (imm_valid && ld_valid) win_ld = PRIO ? 1'b0 : !m_last_ld;
            else win_ld = ld_valid;
            e_irdy = free && imm_valid && !win_ld;
            e_lrdy = free && ld_valid && win_ld;
            chk("rnd_imm_rdy", 32'(imm_ready), 32'(e_irdy));
            chk("rnd_ld_rdy", 32'(ld_ready), 32'(e_lrdy));
            imm_acc = e_irdy;
            ld_acc = e_lrdy;
            if (e_irdy) begin
                m_valid = 1'b1;
                m_data = ref_imm(imm_data, imm_mode);
                m_src = 1'b0;
                m_last_ld = 1'b0;
            end else if (e_lrdy) begin
                m_valid = 1'b1;
                m_data = ref_ld(ld_word, ld_offset, ld_size, ld_signed);
                m_src = 1'b1;
                m_last_ld = 1'b1;
            end else if (res_ready) begin
                m_valid = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
